// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: memory address/data, decoder valid/ready handshake, jump request and status.
// The fetch unit is the master side; the memory/decoder environment is the slave side.
interface instr_fetch_if #(
    parameter int PC_W   = 3,
    parameter int IC_W   = 3,
    parameter int DATA_W = 8
);
    logic                 en;
    logic [PC_W+IC_W-1:0] addr;
    logic [DATA_W-1:0]    mem_data;
    logic [DATA_W-1:0]    data;
    logic [DATA_W-1:0]    opcode;
    logic                 valid;
    logic                 ready;
    logic                 jump;
    logic [PC_W-1:0]      jump_pc;
    logic [PC_W-1:0]      pc;
    logic                 halted;

    modport master (
        input  en, mem_data, ready, jump, jump_pc,
        output addr, data, opcode, valid, pc, halted
    );
    modport slave (
        output en, mem_data, ready, jump, jump_pc,
        input  addr, data, opcode, valid, pc, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch sequencer: data byte at even address, opcode at odd, held for decode.
// Optional INSTR_FETCH_JUMP_EN adds a jump-to-page on the decode handshake.
module instr_fetch #(
    parameter int                PC_W        = 3,
    parameter int                IC_W        = 3,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hC0
) (
    input  logic           instr_fetch_clk,
    input  logic           instr_fetch_rst,
    instr_fetch_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH_DATA, FETCH_OP, HOLD, HALT
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IC_W-1:0]   ic_q, ic_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              handshake;

    assign handshake = valid_q & bus.ready;

`ifndef INSTR_FETCH_JUMP_EN
    logic unused_jump;
    assign unused_jump = ^{bus.jump, bus.jump_pc};
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ic_d     = ic_q;
        data_d   = data_q;
        opcode_d = opcode_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = FETCH_DATA;
            end
            FETCH_DATA: begin
                data_d  = bus.mem_data;
                ic_d    = ic_q + IC_W'(1);
                state_d = FETCH_OP;
            end
            FETCH_OP: begin
                opcode_d = bus.mem_data;
                ic_d     = ic_q + IC_W'(1);
                // leaving the last slot of a page steps to the next page
                if (ic_q == '1) pc_d = pc_q + PC_W'(1);
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (opcode_q == HALT_OPCODE) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
`ifdef INSTR_FETCH_JUMP_EN
                        if (bus.jump) begin
                            pc_d = bus.jump_pc;
                            ic_d = '0;
                        end
`endif
                        state_d = bus.en ? FETCH_DATA : IDLE;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge instr_fetch_clk) begin
        if (instr_fetch_rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ic_q     <= '0;
            data_q   <= '0;
            opcode_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ic_q     <= ic_d;
            data_q   <= data_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.addr   = {pc_q, ic_q};
    assign bus.data   = data_q;
    assign bus.opcode = opcode_q;
    assign bus.valid  = valid_q;
    assign bus.pc     = pc_q;
    assign bus.halted = halted_q;
endmodule
